// File: rtl/rc_parser.sv
// Requester Completion parser: decodes the 96-bit RC descriptor and realigns payload to DW0-aligned beats.
// Optional feature: define RC_ERR_CNT_EN to add the saturating cpl_err_cnt error counter port.
module rc_parser #(
    parameter int DATA_WIDTH = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   m_axis_rc_tdata,
    input  logic                    m_axis_rc_tvalid,
    input  logic [74:0]             m_axis_rc_tuser,
    input  logic [7:0]              m_axis_rc_tkeep,
    input  logic                    m_axis_rc_tlast,
    output logic                    m_axis_rc_tready,
    output logic [DATA_WIDTH-1:0]   cpl_payload,
    output logic [7:0]              cpl_dw_keep,
    output logic                    cpl_valid,
    output logic                    cpl_sop,
    output logic                    cpl_last,
    output logic [7:0]              cpl_tag,
    output logic [10:0]             cpl_dw_count,
    output logic [12:0]             cpl_byte_count,
    output logic [3:0]              cpl_error_code,
    output logic [2:0]              cpl_status,
    output logic                    cpl_req_done,
    output logic                    cpl_poisoned,
    input  logic                    cpl_ready
`ifdef RC_ERR_CNT_EN
    ,
    output logic [15:0]             cpl_err_cnt
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_BODY, ST_FLUSH} state_t;

    function automatic logic [3:0] cnt_ones(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

    function automatic logic [7:0] keep_mask(input logic [3:0] n);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) if (i < int'(n)) m[i] = 1'b1;
        return m;
    endfunction

    state_t          state_q, state_d;
    logic [159:0]    hold_q, hold_d;
    logic [3:0]      hold_cnt_q, hold_cnt_d;
    logic            sop_pend_q, sop_pend_d;
    logic            en_q;

    logic [255:0]    payload_q, payload_raw_d, payload_d;
    logic [7:0]      keep_q, keep_d;
    logic            valid_q, valid_d;
    logic            sop_q, sop_d, last_q, last_d;
    logic [7:0]      tag_q, tag_d;
    logic [10:0]     dwc_q, dwc_d;
    logic [12:0]     bc_q, bc_d;
    logic [3:0]      err_q, err_d;
    logic [2:0]      st_q, st_d;
    logic            done_q, done_d, poison_q, poison_d;

    logic            out_free, tready, accept;
    logic [3:0]      cnt_hi, cnt_lo;
    logic [255:0]    keep_bits;

    assign out_free = ~valid_q | cpl_ready;
    assign tready   = en_q & ~rst & (state_q != ST_FLUSH) & out_free;
    assign accept   = m_axis_rc_tvalid & tready;
    assign cnt_hi   = cnt_ones({3'b000, m_axis_rc_tkeep[7:3]});
    assign cnt_lo   = cnt_ones({5'b00000, m_axis_rc_tkeep[2:0]});

    // Lanes outside keep are forced to zero so downstream never sees stale DWs.
    for (genvar gi = 0; gi < 8; gi++) begin : g_keep_bits
        assign keep_bits[gi*32 +: 32] = {32{keep_d[gi]}};
    end
    assign payload_d = payload_raw_d & keep_bits;

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        hold_cnt_d    = hold_cnt_q;
        sop_pend_d    = sop_pend_q;
        valid_d       = valid_q & ~cpl_ready;
        payload_raw_d = payload_q;
        keep_d        = keep_q;
        sop_d         = sop_q;
        last_d        = last_q;
        tag_d         = tag_q;
        dwc_d         = dwc_q;
        bc_d          = bc_q;
        err_d         = err_q;
        st_d          = st_q;
        done_d        = done_q;
        poison_d      = poison_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tag_d      = m_axis_rc_tdata[71:64];
                    dwc_d      = m_axis_rc_tdata[42:32];
                    bc_d       = m_axis_rc_tdata[28:16];
                    err_d      = m_axis_rc_tdata[15:12];
                    st_d       = m_axis_rc_tdata[45:43];
                    done_d     = m_axis_rc_tdata[30];
                    poison_d   = m_axis_rc_tdata[46];
                    hold_d     = m_axis_rc_tdata[255:96];
                    hold_cnt_d = cnt_hi;
                    if (m_axis_rc_tlast) begin
                        valid_d       = 1'b1;
                        payload_raw_d = {96'b0, m_axis_rc_tdata[255:96]};
                        keep_d        = keep_mask(cnt_hi);
                        sop_d         = 1'b1;
                        last_d        = 1'b1;
                        hold_cnt_d    = '0;
                    end else begin
                        sop_pend_d = 1'b1;
                        state_d    = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (accept) begin
                    valid_d       = 1'b1;
                    payload_raw_d = {m_axis_rc_tdata[95:0], hold_q};
                    sop_d         = sop_pend_q;
                    sop_pend_d    = 1'b0;
                    hold_d        = m_axis_rc_tdata[255:96];
                    hold_cnt_d    = cnt_hi;
                    keep_d        = 8'hFF;
                    last_d        = 1'b0;
                    if (m_axis_rc_tlast && !m_axis_rc_tkeep[3]) begin
                        keep_d     = keep_mask(4'd5 + cnt_lo);
                        last_d     = 1'b1;
                        hold_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else if (m_axis_rc_tlast) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    valid_d       = 1'b1;
                    payload_raw_d = {96'b0, hold_q};
                    keep_d        = keep_mask(hold_cnt_q);
                    sop_d         = 1'b0;
                    last_d        = 1'b1;
                    hold_cnt_d    = '0;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            hold_cnt_q <= '0;
            sop_pend_q <= 1'b0;
            en_q       <= 1'b0;
            payload_q  <= '0;
            keep_q     <= '0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            last_q     <= 1'b0;
            tag_q      <= '0;
            dwc_q      <= '0;
            bc_q       <= '0;
            err_q      <= '0;
            st_q       <= '0;
            done_q     <= 1'b0;
            poison_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            sop_pend_q <= sop_pend_d;
            en_q       <= 1'b1;
            payload_q  <= payload_d;
            keep_q     <= keep_d;
            valid_q    <= valid_d;
            sop_q      <= sop_d;
            last_q     <= last_d;
            tag_q      <= tag_d;
            dwc_q      <= dwc_d;
            bc_q       <= bc_d;
            err_q      <= err_d;
            st_q       <= st_d;
            done_q     <= done_d;
            poison_q   <= poison_d;
        end
    end

`ifdef RC_ERR_CNT_EN
    logic [15:0] err_cnt_q;
    logic        err_hit;

    // tuser[42] flags a discontinued completion from the core.
    assign err_hit = accept && (state_q == ST_IDLE) &&
                     ((m_axis_rc_tdata[45:43] != 3'b000) || (m_axis_rc_tdata[15:12] != 4'h0) ||
                      m_axis_rc_tuser[42]);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (err_hit && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end
    assign cpl_err_cnt = err_cnt_q;
`endif

    logic unused_bits;
    assign unused_bits = ^{m_axis_rc_tuser, m_axis_rc_tdata[95:72], m_axis_rc_tdata[63:47],
                           m_axis_rc_tdata[31], m_axis_rc_tdata[29], m_axis_rc_tdata[11:0]};

    assign m_axis_rc_tready = tready;
    assign cpl_payload      = payload_q;
    assign cpl_dw_keep      = keep_q;
    assign cpl_valid        = valid_q;
    assign cpl_sop          = sop_q;
    assign cpl_last         = last_q;
    assign cpl_tag          = tag_q;
    assign cpl_dw_count     = dwc_q;
    assign cpl_byte_count   = bc_q;
    assign cpl_error_code   = err_q;
    assign cpl_status       = st_q;
    assign cpl_req_done     = done_q;
    assign cpl_poisoned     = poison_q;

endmodule

// File: tb/tb_rc_parser.sv
// Scoreboard bench for rc_parser: a DW-level reference model queues expected output beats per completion.
// Define RC_ERR_CNT_EN to also exercise the error counter.
module tb_rc_parser;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] m_axis_rc_tdata;
    logic         m_axis_rc_tvalid;
    logic [74:0]  m_axis_rc_tuser;
    logic [7:0]   m_axis_rc_tkeep;
    logic         m_axis_rc_tlast;
    logic         m_axis_rc_tready;
    logic [255:0] cpl_payload;
    logic [7:0]   cpl_dw_keep;
    logic         cpl_valid, cpl_sop, cpl_last;
    logic [7:0]   cpl_tag;
    logic [10:0]  cpl_dw_count;
    logic [12:0]  cpl_byte_count;
    logic [3:0]   cpl_error_code;
    logic [2:0]   cpl_status;
    logic         cpl_req_done, cpl_poisoned;
    logic         cpl_ready;
`ifdef RC_ERR_CNT_EN
    logic [15:0]  cpl_err_cnt;
`endif

    always #5 clk = ~clk;

    rc_parser #(.DATA_WIDTH(256)) dut (
        .clk(clk), .rst(rst),
        .m_axis_rc_tdata(m_axis_rc_tdata), .m_axis_rc_tvalid(m_axis_rc_tvalid),
        .m_axis_rc_tuser(m_axis_rc_tuser), .m_axis_rc_tkeep(m_axis_rc_tkeep),
        .m_axis_rc_tlast(m_axis_rc_tlast), .m_axis_rc_tready(m_axis_rc_tready),
        .cpl_payload(cpl_payload), .cpl_dw_keep(cpl_dw_keep), .cpl_valid(cpl_valid),
        .cpl_sop(cpl_sop), .cpl_last(cpl_last), .cpl_tag(cpl_tag),
        .cpl_dw_count(cpl_dw_count), .cpl_byte_count(cpl_byte_count),
        .cpl_error_code(cpl_error_code), .cpl_status(cpl_status),
        .cpl_req_done(cpl_req_done), .cpl_poisoned(cpl_poisoned),
        .cpl_ready(cpl_ready)
`ifdef RC_ERR_CNT_EN
        , .cpl_err_cnt(cpl_err_cnt)
`endif
    );

    typedef struct packed {
        logic [255:0] payload;
        logic [7:0]   keep;
        logic         sop;
        logic         last;
        logic [7:0]   tag;
        logic [10:0]  dwc;
        logic [12:0]  bc;
        logic [3:0]   err;
        logic [2:0]   st;
        logic         done;
        logic         poison;
    } beat_t;

    typedef struct packed {
        logic [7:0]  tag;
        logic [10:0] dwc;
        logic [12:0] bc;
        logic [3:0]  err;
        logic [2:0]  st;
        logic        done;
        logic        poison;
    } desc_t;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    checks = 0;
    int    errors = 0;

    always @(negedge clk) begin : monitor
        beat_t b;
        if (!rst && cpl_valid && cpl_ready) begin
            b.payload = cpl_payload;
            for (int j = 0; j < 8; j++) if (!cpl_dw_keep[j]) b.payload[j*32 +: 32] = '0;
            b.keep = cpl_dw_keep;  b.sop = cpl_sop;      b.last = cpl_last;
            b.tag  = cpl_tag;      b.dwc = cpl_dw_count; b.bc   = cpl_byte_count;
            b.err  = cpl_error_code; b.st = cpl_status;  b.done = cpl_req_done;
            b.poison = cpl_poisoned;
            obs_q.push_back(b);
        end
    end

    function automatic logic [7:0] kmask(input int n);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) if (i < n) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [95:0] mk_desc(input desc_t d);
        logic [95:0] r;
        r = '0;
        r[71:64] = d.tag;  r[42:32] = d.dwc; r[28:16] = d.bc; r[15:12] = d.err;
        r[45:43] = d.st;   r[30] = d.done;   r[46] = d.poison;
        return r;
    endfunction

    task automatic send_beat(input logic [255:0] data, input logic [7:0] keep, input logic last);
        logic ok;
        m_axis_rc_tdata = data; m_axis_rc_tkeep = keep; m_axis_rc_tlast = last;
        m_axis_rc_tvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (m_axis_rc_tready) ok = 1'b1;
            @(posedge clk); #1;
        end
        m_axis_rc_tvalid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout tready stayed 0, required 1");
        end
    endtask

    // Reference model: payload DWs packed 8 per output beat, zero-payload gives one empty beat.
    task automatic send_tlp(input desc_t d, input int n, input logic [31:0] base);
        logic [31:0]  dws[$];
        beat_t        e;
        logic [255:0] data;
        int           nb, cnt, idx;
        for (int i = 0; i < n; i++) dws.push_back(base ^ (32'h01030507 * 32'(i)));
        nb = (n == 0) ? 1 : (n + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            e = '0;
            e.tag = d.tag; e.dwc = d.dwc; e.bc = d.bc; e.err = d.err;
            e.st = d.st; e.done = d.done; e.poison = d.poison;
            cnt = (n - 8*b > 8) ? 8 : n - 8*b;
            for (int j = 0; j < cnt; j++) e.payload[j*32 +: 32] = dws[8*b + j];
            e.keep = kmask(cnt);
            e.sop  = (b == 0);
            e.last = (b == nb - 1);
            exp_q.push_back(e);
        end
        cnt  = (n > 5) ? 5 : n;
        data = '0;
        data[95:0] = mk_desc(d);
        for (int j = 0; j < cnt; j++) data[96 + 32*j +: 32] = dws[j];
        send_beat(data, kmask(3 + cnt), n <= 5);
        idx = cnt;
        while (idx < n) begin
            cnt  = (n - idx > 8) ? 8 : n - idx;
            data = '0;
            for (int j = 0; j < cnt; j++) data[32*j +: 32] = dws[idx + j];
            send_beat(data, kmask(cnt), idx + cnt >= n);
            idx += cnt;
        end
    endtask

    task automatic wait_obs(input int n, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            if (obs_q.size() >= n) ok = 1'b1;
            else @(posedge clk);
        end
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; m_axis_rc_tvalid = 1'b0; cpl_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cpl_valid, cpl_sop, cpl_last, cpl_dw_keep, cpl_payload, cpl_tag, cpl_dw_count,
             cpl_byte_count, cpl_error_code, cpl_status, cpl_req_done, cpl_poisoned,
             m_axis_rc_tready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs valid=%b tready=%b keep=%h tag=%h, required all 0",
                     cpl_valid, m_axis_rc_tready, cpl_dw_keep, cpl_tag);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_axis_rc_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_tready got %b required 1", m_axis_rc_tready);
        end
    endtask

    task automatic test_single_dw;
        desc_t d;
        beat_t e, o;
        logic  ok;
        @(posedge clk); #1;
        d = '{tag: 8'h05, dwc: 11'd1, bc: 13'd4, err: 4'h0, st: 3'd0, done: 1'b1, poison: 1'b0};
        send_tlp(d, 1, 32'hA5A5A5A5);
        @(negedge clk);
        checks++;
        if (cpl_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_dw_latency cpl_valid got %b required 1", cpl_valid);
        end
        wait_obs(exp_q.size(), ok);
        if (!ok) begin checks++; errors++; $display("FAIL single_dw_timeout got %0d beats", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL single_dw_beat got %h required %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_tready_profile(input string name, input int n, input int req_lows);
        desc_t d;
        beat_t e, o;
        logic  ok;
        int    lows;
        @(posedge clk); #1;
        lows = 0;
        d = '{tag: 8'(n + 8'h40), dwc: 11'(n), bc: 13'(4*n), err: 4'h0, st: 3'd0, done: 1'b1, poison: 1'b1};
        fork
            send_tlp(d, n, 32'h1000_0000 + 32'(n));
            begin
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    if (!m_axis_rc_tready) lows++;
                end
            end
        join
        checks++;
        if (lows !== req_lows) begin
            errors++;
            $display("FAIL %s_tready_low_cycles got %0d required %0d", name, lows, req_lows);
        end
        wait_obs(exp_q.size(), ok);
        if (!ok) begin checks++; errors++; $display("FAIL %s_timeout got %0d beats", name, obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL %s_beat got %h required %h", name, o, e); end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL %s_extra_beats got %0d required 0", name, obs_q.size()); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_stall;
        desc_t d1, d2;
        beat_t e, o;
        logic  ok, seen;
        @(posedge clk); #1;
        d1 = '{tag: 8'h16, dwc: 11'd16, bc: 13'd64, err: 4'h0, st: 3'd0, done: 1'b1, poison: 1'b0};
        d2 = '{tag: 8'h17, dwc: 11'd1, bc: 13'd4, err: 4'h0, st: 3'd0, done: 1'b1, poison: 1'b0};
        fork
            begin
                send_tlp(d1, 16, 32'hC0DE0000);
                send_tlp(d2, 1, 32'h0BADF00D);
            end
            begin
                seen = 1'b0;
                for (int c = 0; c < 50 && !seen; c++) begin
                    @(negedge clk);
                    if (cpl_valid) seen = 1'b1;
                end
                @(posedge clk); #1 cpl_ready = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    checks++;
                    if (m_axis_rc_tready !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_tready cycle %0d got %b required 0", c, m_axis_rc_tready);
                    end
                end
                @(posedge clk); #1 cpl_ready = 1'b1;
            end
        join
        wait_obs(exp_q.size(), ok);
        if (!ok) begin checks++; errors++; $display("FAIL stall_timeout got %0d beats", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL stall_beat got %h required %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back;
        desc_t d;
        beat_t e, o;
        logic  ok;
        int    sizes[4] = '{3, 13, 0, 7};
        @(posedge clk); #1;
        for (int t = 0; t < 4; t++) begin
            d = '{tag: 8'(8'h80 + t), dwc: 11'(sizes[t]), bc: 13'(4*sizes[t] + t), err: 4'(t),
                  st: 3'd0, done: t[0], poison: 1'b0};
            send_tlp(d, sizes[t], $urandom);
        end
        wait_obs(exp_q.size(), ok);
        if (!ok) begin checks++; errors++; $display("FAIL b2b_timeout got %0d beats", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL b2b_beat got %h required %h", o, e); end
        end
        repeat (3) @(posedge clk);
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL b2b_extra_beats got %0d required 0", obs_q.size()); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_ur_error;
        desc_t d;
        beat_t e, o;
        logic  ok;
        @(posedge clk); #1;
`ifdef RC_ERR_CNT_EN
        checks++;
        if (cpl_err_cnt !== 16'd0) begin errors++; $display("FAIL ur_err_cnt_before got %0d required 0", cpl_err_cnt); end
`endif
        d = '{tag: 8'h2A, dwc: 11'd0, bc: 13'd0, err: 4'h3, st: 3'b001, done: 1'b1, poison: 1'b0};
        send_tlp(d, 0, 32'h0);
        wait_obs(exp_q.size(), ok);
        if (!ok) begin checks++; errors++; $display("FAIL ur_timeout got %0d beats", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL ur_beat got %h required %h", o, e); end
        end
`ifdef RC_ERR_CNT_EN
        checks++;
        if (cpl_err_cnt !== 16'd1) begin errors++; $display("FAIL ur_err_cnt_after got %0d required 1", cpl_err_cnt); end
`endif
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid;
        desc_t d;
        beat_t e, o;
        logic  ok;
        logic [255:0] data;
        @(posedge clk); #1;
        d = '{tag: 8'h99, dwc: 11'd16, bc: 13'd64, err: 4'h0, st: 3'd0, done: 1'b0, poison: 1'b0};
        data = {$urandom, $urandom, $urandom, $urandom, $urandom, 96'b0};
        data[95:0] = mk_desc(d);
        send_beat(data, 8'hFF, 1'b0);
        send_beat({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 8'hFF, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cpl_valid, cpl_sop, cpl_last, cpl_dw_keep, cpl_payload, cpl_tag, cpl_dw_count,
             cpl_byte_count, cpl_error_code, cpl_status, cpl_req_done, cpl_poisoned,
             m_axis_rc_tready} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs valid=%b keep=%h tag=%h tready=%b, required all 0",
                     cpl_valid, cpl_dw_keep, cpl_tag, m_axis_rc_tready);
        end
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete(); obs_q.delete();
        d = '{tag: 8'h3C, dwc: 11'd1, bc: 13'd4, err: 4'h0, st: 3'd0, done: 1'b1, poison: 1'b0};
        send_tlp(d, 1, 32'h600D_CAFE);
        wait_obs(exp_q.size(), ok);
        if (!ok) begin checks++; errors++; $display("FAIL reset_mid_timeout got %0d beats", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL reset_mid_beat got %h required %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        m_axis_rc_tdata = '0; m_axis_rc_tvalid = 1'b0; m_axis_rc_tuser = '0;
        m_axis_rc_tkeep = '0; m_axis_rc_tlast = 1'b0; cpl_ready = 1'b1;
        test_reset();
        test_single_dw();
        test_tready_profile("eight_dw", 8, 0);
        test_tready_profile("nine_dw", 9, 1);
        test_stall();
        test_back_to_back();
        test_ur_error();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
